// File: rtl/inst_decode.sv
// RV32I decode stage: field/immediate extraction, register-use flags, load-use hazard detection.
// Latency 1 cycle; STALL freezes all D_* outputs, HAZARD requests fetch to hold and inserts one bubble.
module inst_decode (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] I_PC,
  input  logic        I_VALID,
  input  logic [31:0] I_INST,
  output logic        HAZARD,
  output logic        D_VALID,
  output logic [31:0] D_PC,
  output logic [6:0]  D_OPCODE,
  output logic [4:0]  D_RD,
  output logic [4:0]  D_RS1,
  output logic [4:0]  D_RS2,
  output logic [2:0]  D_FUNCT3,
  output logic [6:0]  D_FUNCT7,
  output logic [31:0] D_IMM,
  output logic        D_USE_RS1,
  output logic        D_USE_RS2,
  output logic        D_ILLEGAL
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        use_rs1;
    logic        use_rs2;
    logic        illegal;
  } dec_t;

  dec_t        dec;
  dec_t        d_q;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        load_pending;
  logic        reads_load_rd;

  assign imm_i = {{20{I_INST[31]}}, I_INST[31:20]};
  assign imm_s = {{20{I_INST[31]}}, I_INST[31:25], I_INST[11:7]};
  assign imm_b = {{19{I_INST[31]}}, I_INST[31], I_INST[7], I_INST[30:25], I_INST[11:8], 1'b0};
  assign imm_u = {I_INST[31:12], 12'h000};
  assign imm_j = {{11{I_INST[31]}}, I_INST[31], I_INST[19:12], I_INST[20], I_INST[30:21], 1'b0};

  always_comb begin
    dec         = '0;
    dec.opcode  = I_INST[6:0];
    dec.rd      = I_INST[11:7];
    dec.rs1     = I_INST[19:15];
    dec.rs2     = I_INST[24:20];
    dec.funct3  = I_INST[14:12];
    dec.funct7  = I_INST[31:25];
    case (I_INST[6:0])
      OP_LUI, OP_AUIPC: dec.imm = imm_u;
      OP_JAL:           dec.imm = imm_j;
      OP_JALR, OP_LOAD, OP_OPIMM: begin
        dec.imm     = imm_i;
        dec.use_rs1 = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm     = imm_b;
        dec.use_rs1 = 1'b1;
        dec.use_rs2 = 1'b1;
        dec.rd      = 5'd0;
      end
      OP_STORE: begin
        dec.imm     = imm_s;
        dec.use_rs1 = 1'b1;
        dec.use_rs2 = 1'b1;
        dec.rd      = 5'd0;
      end
      OP_OP: begin
        dec.use_rs1 = 1'b1;
        dec.use_rs2 = 1'b1;
      end
      OP_MISC: begin
        dec.imm = imm_i;
        dec.rd  = 5'd0;
      end
      OP_SYSTEM: dec.imm = imm_i;
      // Every listed opcode ends in 2'b11, so this also catches compressed encodings.
      default: begin
        dec.illegal = 1'b1;
        dec.rd      = 5'd0;
      end
    endcase
  end

  // Independent of STALL: a held load keeps requesting the hold, but the bubble only lands once STALL drops.
  assign load_pending  = D_VALID && (D_OPCODE == OP_LOAD) && (D_RD != 5'd0);
  assign reads_load_rd = (dec.use_rs1 && (dec.rs1 == D_RD)) || (dec.use_rs2 && (dec.rs2 == D_RD));
  assign HAZARD        = load_pending && I_VALID && !FLUSH && reads_load_rd;

  always_ff @(posedge CLK) begin
    if (RST) begin
      D_VALID <= 1'b0;
      D_PC    <= '0;
      d_q     <= '0;
    end else if (FLUSH) begin
      D_VALID <= 1'b0;
    end else if (!STALL) begin
      if (HAZARD) begin
        D_VALID <= 1'b0;
      end else begin
        D_VALID <= I_VALID;
        D_PC    <= I_PC;
        d_q     <= dec;
      end
    end
  end

  assign D_OPCODE  = d_q.opcode;
  assign D_RD      = d_q.rd;
  assign D_RS1     = d_q.rs1;
  assign D_RS2     = d_q.rs2;
  assign D_FUNCT3  = d_q.funct3;
  assign D_FUNCT7  = d_q.funct7;
  assign D_IMM     = d_q.imm;
  assign D_USE_RS1 = d_q.use_rs1;
  assign D_USE_RS2 = d_q.use_rs2;
  assign D_ILLEGAL = d_q.illegal;

endmodule

// File: tb/tb_inst_decode.sv
// Bench for inst_decode: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_inst_decode;

  logic        CLK = 1'b0;
  logic        RST, STALL, FLUSH, I_VALID;
  logic [31:0] I_PC, I_INST;
  logic        HAZARD, D_VALID, D_USE_RS1, D_USE_RS2, D_ILLEGAL;
  logic [31:0] D_PC, D_IMM;
  logic [6:0]  D_OPCODE, D_FUNCT7;
  logic [4:0]  D_RD, D_RS1, D_RS2;
  logic [2:0]  D_FUNCT3;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  inst_decode dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .I_PC(I_PC), .I_VALID(I_VALID), .I_INST(I_INST),
    .HAZARD(HAZARD), .D_VALID(D_VALID), .D_PC(D_PC), .D_OPCODE(D_OPCODE),
    .D_RD(D_RD), .D_RS1(D_RS1), .D_RS2(D_RS2), .D_FUNCT3(D_FUNCT3),
    .D_FUNCT7(D_FUNCT7), .D_IMM(D_IMM), .D_USE_RS1(D_USE_RS1),
    .D_USE_RS2(D_USE_RS2), .D_ILLEGAL(D_ILLEGAL)
  );

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        u1, u2, ill;
  } ref_t;

  // Immediates built from arithmetic right shifts of the signed word, then masked and OR-ed.
  function automatic ref_t ref_decode(input logic [31:0] inst);
    ref_t r;
    logic signed [31:0] s;
    logic [31:0] sh11, sh19, sh20;
    s    = $signed(inst);
    sh11 = s >>> 11;
    sh19 = s >>> 19;
    sh20 = s >>> 20;
    r.opcode = inst[6:0];
    r.rd  = inst[11:7];
    r.rs1 = inst[19:15];
    r.rs2 = inst[24:20];
    r.f3  = inst[14:12];
    r.f7  = inst[31:25];
    r.imm = 32'd0;
    r.u1  = 1'b0;
    r.u2  = 1'b0;
    r.ill = 1'b0;
    case (inst[6:0])
      7'b0110111, 7'b0010111: r.imm = inst & 32'hFFFFF000;
      7'b1101111: r.imm = (sh11 & 32'hFFF00000) | ({24'd0, inst[19:12]} << 12)
                          | ({31'd0, inst[20]} << 11) | ({22'd0, inst[30:21]} << 1);
      7'b1100111, 7'b0000011, 7'b0010011: begin r.imm = sh20; r.u1 = 1'b1; end
      7'b1100011: begin
        r.imm = (sh19 & 32'hFFFFF000) | ({31'd0, inst[7]} << 11)
                | ({26'd0, inst[30:25]} << 5) | ({28'd0, inst[11:8]} << 1);
        r.u1 = 1'b1; r.u2 = 1'b1; r.rd = 5'd0;
      end
      7'b0100011: begin
        r.imm = (sh20 & 32'hFFFFFFE0) | {27'd0, inst[11:7]};
        r.u1 = 1'b1; r.u2 = 1'b1; r.rd = 5'd0;
      end
      7'b0110011: begin r.u1 = 1'b1; r.u2 = 1'b1; end
      7'b0001111: begin r.imm = sh20; r.rd = 5'd0; end
      7'b1110011: r.imm = sh20;
      default: begin r.ill = 1'b1; r.rd = 5'd0; end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  op;
    case ($urandom_range(13))
      0: op = 7'b0110111;  1: op = 7'b0010111;  2: op = 7'b1101111;
      3: op = 7'b1100111;  4: op = 7'b1100011;  5, 6, 7: op = 7'b0000011;
      8: op = 7'b0100011;  9: op = 7'b0010011;  10: op = 7'b0110011;
      11: op = 7'b0001111; 12: op = 7'b1110011;
      default: op = 7'($urandom);
    endcase
    w = $urandom;
    if ($urandom_range(3) != 0) begin
      w[11:7]  = 5'($urandom_range(3));
      w[19:15] = 5'($urandom_range(3));
      w[24:20] = 5'($urandom_range(3));
    end
    w[6:0] = op;
    return w;
  endfunction

  task automatic drive(input logic stall, input logic flush, input logic vld,
                       input logic [31:0] pc, input logic [31:0] inst);
    STALL = stall; FLUSH = flush; I_VALID = vld; I_PC = pc; I_INST = inst;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checks++;
    if (D_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", D_VALID); end
    checks++;
    if (D_PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", D_PC); end
    checks++;
    if (D_ILLEGAL !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", D_ILLEGAL); end
    checks++;
    if ({D_OPCODE, D_RD, D_RS1, D_RS2, D_FUNCT3, D_FUNCT7, D_IMM, D_USE_RS1, D_USE_RS2} !== '0) begin
      errors++; $display("FAIL reset_fields: got imm=%h rd=%0d op=%b want all 0", D_IMM, D_RD, D_OPCODE);
    end
    checks++;
    if (HAZARD !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b want 0", HAZARD); end
    RST = 1'b0;
  endtask

  task automatic test_addi();
    drive(1'b0, 1'b0, 1'b1, 32'h20000000, 32'h00500093);
    tick();
    checks++;
    if ({D_VALID, D_PC, D_RD, D_RS1, D_IMM, D_USE_RS1, D_USE_RS2}
        !== {1'b1, 32'h20000000, 5'd1, 5'd0, 32'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL addi: got v=%b pc=%h rd=%0d rs1=%0d imm=%h u1=%b u2=%b want 1 20000000 1 0 00000005 1 0",
               D_VALID, D_PC, D_RD, D_RS1, D_IMM, D_USE_RS1, D_USE_RS2);
    end
    checks++;
    if (D_ILLEGAL !== 1'b0) begin errors++; $display("FAIL addi_illegal: got %b want 0", D_ILLEGAL); end
  endtask

  task automatic test_beq_lui();
    drive(1'b0, 1'b0, 1'b1, 32'h100, 32'hFE000CE3);
    tick();
    checks++;
    if ({D_IMM, D_RD, D_USE_RS1, D_USE_RS2} !== {32'hFFFFFFF8, 5'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL beq: got imm=%h rd=%0d u1=%b u2=%b want fffffff8 0 1 1", D_IMM, D_RD, D_USE_RS1, D_USE_RS2);
    end
    drive(1'b0, 1'b0, 1'b1, 32'h104, 32'h123452B7);
    tick();
    checks++;
    if ({D_VALID, D_IMM, D_RD, D_USE_RS1, D_USE_RS2} !== {1'b1, 32'h12345000, 5'd5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL lui: got v=%b imm=%h rd=%0d u1=%b u2=%b want 1 12345000 5 0 0",
               D_VALID, D_IMM, D_RD, D_USE_RS1, D_USE_RS2);
    end
  endtask

  task automatic test_load_use();
    drive(1'b0, 1'b0, 1'b1, 32'h200, 32'h0000A103);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h204, 32'h001101B3);
    #1;
    checks++;
    if (HAZARD !== 1'b1) begin errors++; $display("FAIL loaduse_hazard: got %b want 1", HAZARD); end
    tick();
    checks++;
    if (D_VALID !== 1'b0) begin errors++; $display("FAIL loaduse_bubble: got valid %b want 0", D_VALID); end
    checks++;
    if (HAZARD !== 1'b0) begin errors++; $display("FAIL loaduse_hazard_clear: got %b want 0", HAZARD); end
    tick();
    checks++;
    if ({D_VALID, D_PC, D_RS1, D_RS2, D_RD} !== {1'b1, 32'h204, 5'd2, 5'd1, 5'd3}) begin
      errors++;
      $display("FAIL loaduse_add: got v=%b pc=%h rs1=%0d rs2=%0d rd=%0d want 1 204 2 1 3",
               D_VALID, D_PC, D_RS1, D_RS2, D_RD);
    end
    drive(1'b0, 1'b0, 1'b1, 32'h300, 32'h0000A003);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h304, 32'h001101B3);
    #1;
    checks++;
    if (HAZARD !== 1'b0) begin errors++; $display("FAIL load_x0_hazard: got %b want 0", HAZARD); end
    tick();
    checks++;
    if ({D_VALID, D_PC, D_RD} !== {1'b1, 32'h304, 5'd3}) begin
      errors++; $display("FAIL load_x0_add: got v=%b pc=%h rd=%0d want 1 304 3", D_VALID, D_PC, D_RD);
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b0, 1'b0, 1'b1, 32'h20000000, 32'h00500093);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, $urandom, rand_inst());
      tick();
      checks++;
      if ({D_VALID, D_PC, D_RD, D_IMM, D_OPCODE} !== {1'b1, 32'h20000000, 5'd1, 32'd5, 7'b0010011}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h rd=%0d imm=%h op=%b want 1 20000000 1 00000005 0010011",
                 i, D_VALID, D_PC, D_RD, D_IMM, D_OPCODE);
      end
    end
    drive(1'b1, 1'b1, 1'b1, 32'h44, 32'h00500093);
    tick();
    checks++;
    if (D_VALID !== 1'b0) begin errors++; $display("FAIL flush_stall: got valid %b want 0", D_VALID); end
    drive(1'b0, 1'b1, 1'b1, 32'h48, 32'h00500093);
    tick();
    checks++;
    if (D_VALID !== 1'b0) begin errors++; $display("FAIL flush_drop: got valid %b want 0", D_VALID); end
  endtask

  task automatic test_illegal();
    logic [31:0] words [2];
    words[0] = 32'h00000000;
    words[1] = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h400, words[i]);
      tick();
      checks++;
      if ({D_ILLEGAL, D_VALID, D_IMM, D_RD, D_USE_RS1, D_USE_RS2} !== {1'b1, 1'b1, 32'd0, 5'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL illegal[%h]: got ill=%b v=%b imm=%h rd=%0d u1=%b u2=%b want 1 1 0 0 0 0",
                 words[i], D_ILLEGAL, D_VALID, D_IMM, D_RD, D_USE_RS1, D_USE_RS2);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b0, 1'b0, 1'b1, 32'h500, 32'h0000A103);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h504, 32'h001101B3);
    #1;
    checks++;
    if (HAZARD !== 1'b1) begin errors++; $display("FAIL stall_hazard: got %b want 1", HAZARD); end
    RST = 1'b1;
    tick();
    checks++;
    if ({D_VALID, D_PC, D_OPCODE, D_RD, D_IMM, D_ILLEGAL, D_USE_RS1, D_USE_RS2} !== '0) begin
      errors++;
      $display("FAIL reset_mid_stall: got v=%b pc=%h op=%b rd=%0d imm=%h want all 0",
               D_VALID, D_PC, D_OPCODE, D_RD, D_IMM);
    end
    checks++;
    if (HAZARD !== 1'b0) begin errors++; $display("FAIL reset_mid_stall_hazard: got %b want 0", HAZARD); end
    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    logic        m_valid;
    logic [31:0] m_pc;
    ref_t        m_dec, cur;
    logic        exp_haz;
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    RST = 1'b0;
    m_valid = 1'b0; m_pc = 32'h0; m_dec = '0;
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(63) == 0);
      drive(($urandom_range(4) == 0), ($urandom_range(9) == 0), ($urandom_range(4) != 0),
            $urandom, rand_inst());
      cur = ref_decode(I_INST);
      exp_haz = m_valid && (m_dec.opcode == 7'b0000011) && (m_dec.rd != 5'd0) && I_VALID && !FLUSH
                && ((cur.u1 && cur.rs1 == m_dec.rd) || (cur.u2 && cur.rs2 == m_dec.rd));
      #1;
      checks++;
      if (HAZARD !== exp_haz) begin
        errors++; $display("FAIL rand_hazard cyc %0d: got %b want %b", c, HAZARD, exp_haz);
      end
      @(posedge CLK);
      if (RST) begin
        m_valid = 1'b0; m_pc = 32'h0; m_dec = '0;
      end else if (FLUSH) begin
        m_valid = 1'b0;
      end else if (!STALL) begin
        if (exp_haz) m_valid = 1'b0;
        else begin m_valid = I_VALID; m_pc = I_PC; m_dec = cur; end
      end
      @(negedge CLK);
      checks++;
      if (D_VALID !== m_valid) begin
        errors++; $display("FAIL rand_valid cyc %0d: got %b want %b", c, D_VALID, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (D_PC !== m_pc || D_OPCODE !== m_dec.opcode || D_FUNCT3 !== m_dec.f3 || D_FUNCT7 !== m_dec.f7) begin
          errors++;
          $display("FAIL rand_fields cyc %0d: got pc=%h op=%b f3=%b f7=%b want %h %b %b %b",
                   c, D_PC, D_OPCODE, D_FUNCT3, D_FUNCT7, m_pc, m_dec.opcode, m_dec.f3, m_dec.f7);
        end
        checks++;
        if (D_IMM !== m_dec.imm) begin
          errors++; $display("FAIL rand_imm cyc %0d op=%b: got %h want %h", c, m_dec.opcode, D_IMM, m_dec.imm);
        end
        checks++;
        if ({D_RD, D_RS1, D_RS2} !== {m_dec.rd, m_dec.rs1, m_dec.rs2}) begin
          errors++;
          $display("FAIL rand_regs cyc %0d: got rd=%0d rs1=%0d rs2=%0d want %0d %0d %0d",
                   c, D_RD, D_RS1, D_RS2, m_dec.rd, m_dec.rs1, m_dec.rs2);
        end
        checks++;
        if ({D_USE_RS1, D_USE_RS2, D_ILLEGAL} !== {m_dec.u1, m_dec.u2, m_dec.ill}) begin
          errors++;
          $display("FAIL rand_flags cyc %0d: got u1=%b u2=%b ill=%b want %b %b %b",
                   c, D_USE_RS1, D_USE_RS2, D_ILLEGAL, m_dec.u1, m_dec.u2, m_dec.ill);
        end
      end
    end
    RST = 1'b0;
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_addi();
    test_beq_lui();
    test_load_use();
    test_stall_flush();
    test_illegal();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
